t06_wall_scan_arbiter: RTL and testbench

Time-multiplexed wall-collision checker for the snake game. It holds one 8-bit position comparator and shares it between two requesters: the snake next-head check and the apple-spawn legality check. For each granted request it scans the wall table one entry per cycle, exits early on a match, and returns a one-cycle done pulse with a hit flag. Round-robin arbitration keeps apple placement from starving while the snake is moving.

---
 rtl/t06_wall_scan_arbiter.sv | 116 +++++++++++
 tb/tb_t06_wall_scan_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t06_wall_scan_arbiter.sv
// Wall-collision checker sharing one position comparator between the snake-head
// and apple-spawn requesters, with round-robin grant and early-exit table scan.
module t06_wall_scan_arbiter #(
  parameter int NUM_WALLS = 25,
  parameter int POS_W     = 8,
  parameter int CNT_W     = 5
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NUM_WALLS*POS_W-1:0] walls,
  input  logic [CNT_W-1:0]           wall_count,
  input  logic                       head_req,
  input  logic [POS_W-1:0]           head_pos,
  output logic                       head_done,
  output logic                       head_hit,
  input  logic                       apple_req,
  input  logic [POS_W-1:0]           apple_pos,
  output logic                       apple_done,
  output logic                       apple_hit,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic {OWN_HEAD, OWN_APPLE} owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_grant;
  logic [POS_W-1:0] pos_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] idx;

  logic [POS_W-1:0] cur_wall;
  logic [CNT_W-1:0] limit_in;
  logic             grant_any;
  logic             grant_head;
  logic             match;
  logic             last_idx;
  logic             finish;
  logic             finish_hit;
  logic             finish_head;

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves cur_wall unassigned (avoids a latch).
    cur_wall = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (idx == CNT_W'(i)) cur_wall = walls[i*POS_W +: POS_W];
    end
  end

  assign limit_in   = (wall_count > CNT_W'(NUM_WALLS)) ? CNT_W'(NUM_WALLS) : wall_count;
  assign grant_any  = head_req || apple_req;
  // On a tie the requester that did not win last time gets the comparator.
  assign grant_head = head_req && (!apple_req || last_grant == OWN_APPLE);
  assign match      = (cur_wall == pos_q);
  assign last_idx   = (idx == limit_q - CNT_W'(1));

  // Result is known one cycle before DONE; outputs are registered on entry to DONE.
  assign finish      = (state == SCAN && (match || last_idx)) ||
                       (state == IDLE && grant_any && limit_in == '0);
  assign finish_hit  = (state == SCAN) && match;
  assign finish_head = (state == SCAN) ? (owner == OWN_HEAD) : grant_head;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      owner      <= OWN_HEAD;
      last_grant <= OWN_APPLE;
      pos_q      <= '0;
      limit_q    <= '0;
      idx        <= '0;
      head_done  <= 1'b0;
      head_hit   <= 1'b0;
      apple_done <= 1'b0;
      apple_hit  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      head_done  <= 1'b0;
      apple_done <= 1'b0;
      if (finish) begin
        if (finish_head) begin
          head_done <= 1'b1;
          head_hit  <= finish_hit;
        end else begin
          apple_done <= 1'b1;
          apple_hit  <= finish_hit;
        end
      end

      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_head ? OWN_HEAD : OWN_APPLE;
            last_grant <= grant_head ? OWN_HEAD : OWN_APPLE;
            pos_q      <= grant_head ? head_pos : apple_pos;
            limit_q    <= limit_in;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= (limit_in == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (match || last_idx) state <= DONE;
          else                   idx   <= idx + CNT_W'(1);
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t06_wall_scan_arbiter.sv
// Randomized scoreboard bench for t06_wall_scan_arbiter: the driver predicts each
// grant's result and done cycle from the table rules; a monitor checks done pulses.
module tb_t06_wall_scan_arbiter;
  localparam int NW     = 25;
  localparam int PW     = 8;
  localparam int CW     = 5;
  localparam int BUSY_N = 16384;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [NW*PW-1:0] walls;
  logic [CW-1:0]    wall_count = '0;
  logic             head_req = 1'b0;
  logic [PW-1:0]    head_pos = '0;
  logic             head_done;
  logic             head_hit;
  logic             apple_req = 1'b0;
  logic [PW-1:0]    apple_pos = '0;
  logic             apple_done;
  logic             apple_hit;
  logic             busy;

  t06_wall_scan_arbiter #(.NUM_WALLS(NW), .POS_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .walls(walls), .wall_count(wall_count),
    .head_req(head_req), .head_pos(head_pos), .head_done(head_done), .head_hit(head_hit),
    .apple_req(apple_req), .apple_pos(apple_pos), .apple_done(apple_done),
    .apple_hit(apple_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] w [NW];
  always_comb begin
    for (int i = 0; i < NW; i++) walls[i*PW +: PW] = w[i];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_head;
    bit hit;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_busy [BUSY_N];
  bit   model_hit_head;
  bit   model_hit_apple;
  bit   model_last_head;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: first matching entry below min(count, NW) decides hit and latency.
  task automatic ref_scan(input logic [PW-1:0] pos, input int cnt, output bit hit, output int lat);
    int lim;
    lim = (cnt > NW) ? NW : cnt;
    hit = 1'b0;
    lat = lim + 1;
    for (int k = 0; k < lim; k++) begin
      if (w[k] == pos) begin
        hit = 1'b1;
        lat = k + 2;
        break;
      end
    end
  endtask

  task automatic fill_avoid(input logic [PW-1:0] pos);
    for (int i = 0; i < NW; i++) begin
      do w[i] = PW'($urandom); while (w[i] == pos);
    end
  endtask

  task automatic mark_busy(input int from, input int to);
    for (int c = from; c <= to; c++) if (c >= 0 && c < BUSY_N) exp_busy[c] = 1'b1;
  endtask

  // Called just after a negedge: raise the requests, predict all grants, then
  // drop each requester's req during its final DONE cycle.
  task automatic run_round(input int nh, input int na, input bit scramble);
    int rh, ra, t, lat;
    bit hw, hit;
    int dcyc[$];
    bit dwho[$];
    bit dlast[$];
    rh = nh;
    ra = na;
    t  = cyc;
    head_req  = (nh > 0);
    apple_req = (na > 0);
    while (rh + ra > 0) begin
      hw = (rh > 0) && (ra == 0 || !model_last_head);
      ref_scan(hw ? head_pos : apple_pos, int'(wall_count), hit, lat);
      exp_q.push_back('{is_head: hw, hit: hit, cyc: t + lat});
      mark_busy(t + 1, t + lat);
      if (hw) rh--; else ra--;
      dcyc.push_back(t + lat);
      dwho.push_back(hw);
      dlast.push_back(hw ? (rh == 0) : (ra == 0));
      model_last_head = hw;
      t = t + lat + 1;
    end
    if (scramble && nh + na == 1) begin
      @(negedge clk);
      head_pos   = PW'($urandom);
      apple_pos  = PW'($urandom);
      wall_count = CW'($urandom);
    end
    for (int i = 0; i < dcyc.size(); i++) begin
      while (cyc < dcyc[i]) @(negedge clk);
      if (dlast[i]) begin
        if (dwho[i]) head_req = 1'b0;
        else         apple_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 nrst = 1'b0;
    model_last_head = 1'b0;
    model_hit_head  = 1'b0;
    model_hit_apple = 1'b0;
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
  endtask

  // Monitor: compares busy and hit hold every cycle, and each done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      check("busy", 32'(busy), (cyc < BUSY_N) ? 32'(exp_busy[cyc]) : 32'd0);
      if (head_done && apple_done) check("both_done", 32'd1, 32'd0);
      if (head_done || apple_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_owner_head", 32'(head_done), 32'(e.is_head));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          if (e.is_head) model_hit_head = e.hit;
          else           model_hit_apple = e.hit;
        end
      end
      check("head_hit", 32'(head_hit), 32'(model_hit_head));
      check("apple_hit", 32'(apple_hit), 32'(model_hit_apple));
    end
  end

  initial begin
    int mode, rc;
    for (int i = 0; i < NW; i++) w[i] = '0;
    model_last_head = 1'b0;
    model_hit_head  = 1'b0;
    model_hit_apple = 1'b0;
    do_reset();
    check("rst_head_done", 32'(head_done), 32'd0);
    check("rst_head_hit", 32'(head_hit), 32'd0);
    check("rst_apple_done", 32'(apple_done), 32'd0);
    check("rst_apple_hit", 32'(apple_hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Head hit at index 3: done 5 cycles after the request is sampled.
    head_pos = 8'h35;
    fill_avoid(8'h35);
    w[3] = 8'h35;
    wall_count = 5'd25;
    run_round(1, 0, 1'b0);

    // Apple miss over the full table: 26 cycles.
    apple_pos = 8'hA1;
    fill_avoid(8'hA1);
    wall_count = 5'd25;
    run_round(0, 1, 1'b0);

    // Both held from reset: alternation H, A, H, A.
    head_pos  = 8'h12;
    apple_pos = 8'h34;
    fill_avoid(8'h12);
    w[7] = 8'h12;
    wall_count = 5'd20;
    do_reset();
    run_round(2, 2, 1'b0);

    // Empty table, clamped count, entry just beyond the limit, duplicates.
    wall_count = 5'd0;
    head_pos = w[0];
    run_round(1, 0, 1'b0);
    head_pos = 8'h5C;
    fill_avoid(8'h5C);
    wall_count = 5'd31;
    run_round(1, 0, 1'b0);
    w[24] = 8'h5C;
    run_round(1, 0, 1'b1);
    fill_avoid(8'h77);
    w[10] = 8'h77;
    head_pos = 8'h77;
    wall_count = 5'd10;
    run_round(1, 0, 1'b0);
    w[2] = 8'h77;
    w[7] = 8'h77;
    apple_pos = 8'h77;
    wall_count = 5'd25;
    run_round(0, 1, 1'b0);

    // Reset mid-scan: outputs clear at once and no done appears.
    head_pos = 8'hE4;
    fill_avoid(8'hE4);
    wall_count = 5'd25;
    rc = cyc;
    head_req = 1'b1;
    mark_busy(rc + 1, rc + 4);
    while (cyc < rc + 4) @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_head_done", 32'(head_done), 32'd0);
    check("midrst_head_hit", 32'(head_hit), 32'd0);
    check("midrst_apple_done", 32'(apple_done), 32'd0);
    check("midrst_apple_hit", 32'(apple_hit), 32'd0);
    head_req = 1'b0;
    model_last_head = 1'b0;
    model_hit_head  = 1'b0;
    model_hit_apple = 1'b0;
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
    w[13] = 8'hE4;
    run_round(1, 0, 1'b0);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NW; i++) w[i] = PW'($urandom);
      wall_count = CW'($urandom_range(0, 31));
      head_pos   = ($urandom_range(0, 1) == 1) ? w[$urandom_range(0, NW - 1)] : PW'($urandom);
      apple_pos  = ($urandom_range(0, 1) == 1) ? w[$urandom_range(0, NW - 1)] : PW'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: run_round(1, 0, 1'b1);
        1: run_round(0, 1, 1'b1);
        2: run_round(1, 1, 1'b0);
        default: run_round(2, 1, 1'b0);
      endcase
    end

    repeat (3) @(negedge clk);
    check("pending_done", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
